// File: rtl/dm_arbiter.sv
// Round-robin arbiter for the single-port data memory: CPU MEM stage vs. host port.
// Optional macro DM_ARB_STATS_EN adds saturating grant/stall statistics counters.
module dm_arbiter #(
  parameter int AW      = 7,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  output logic [31:0]   host_rdata,
  output logic          host_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
`ifdef DM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_cpu_grants,
  output logic [31:0]   stat_host_grants,
  output logic [31:0]   stat_stall_cycles
`endif
);

  localparam int CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;

  state_t        state, state_d;
  owner_t        owner, owner_d, last_owner, last_owner_d;
  logic          lat_we, lat_we_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          mem_en_d, mem_we_d, cpu_done_d, host_ack_d;
  logic [AW-1:0] mem_addr_d;
  logic [31:0]   mem_wdata_d, cpu_rdata_d, host_rdata_d;
  logic          grant_cpu, grant_host;

  // Tie goes to whoever did not own the memory last; last_owner resets to HOST so CPU wins first.
  assign grant_cpu  = cpu_req & (~host_req | (last_owner == OWN_HOST));
  assign grant_host = host_req & ~grant_cpu;

  assign cpu_stall  = cpu_req & ~cpu_done;

  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    lat_we_d     = lat_we;
    cnt_d        = cnt;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    cpu_done_d   = 1'b0;
    host_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    host_rdata_d = host_rdata;
    case (state)
      S_IDLE: begin
        if (grant_cpu) begin
          owner_d     = OWN_CPU;
          lat_we_d    = cpu_we;
          mem_en_d    = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          state_d     = S_ISSUE;
        end else if (grant_host) begin
          owner_d     = OWN_HOST;
          lat_we_d    = host_we;
          mem_en_d    = 1'b1;
          mem_we_d    = host_we;
          mem_addr_d  = host_addr;
          mem_wdata_d = host_wdata;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          // mem_rdata is valid in this last WAIT cycle; writes leave rdata untouched.
          if (!lat_we && owner == OWN_CPU)  cpu_rdata_d  = mem_rdata;
          if (!lat_we && owner == OWN_HOST) host_rdata_d = mem_rdata;
          cpu_done_d = (owner == OWN_CPU);
          host_ack_d = (owner == OWN_HOST);
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        last_owner_d = owner;
        owner_d      = OWN_NONE;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_NONE;
      last_owner <= OWN_HOST;
      lat_we     <= 1'b0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_done   <= 1'b0;
      host_ack   <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      lat_we     <= lat_we_d;
      cnt        <= cnt_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_done   <= cpu_done_d;
      host_ack   <= host_ack_d;
      cpu_rdata  <= cpu_rdata_d;
      host_rdata <= host_rdata_d;
    end
  end

`ifdef DM_ARB_STATS_EN
  // Done/ack pulses last exactly one DONE cycle, so each pulse counts one grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cpu_grants   <= '0;
      stat_host_grants  <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (cpu_done  && stat_cpu_grants   != '1) stat_cpu_grants   <= stat_cpu_grants + 1'b1;
      if (host_ack  && stat_host_grants  != '1) stat_host_grants  <= stat_host_grants + 1'b1;
      if (cpu_stall && stat_stall_cycles != '1) stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) with behavioural DM models.
module tb_dm_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        c1_req = 0, c1_we = 0, h1_req = 0, h1_we = 0;
  logic [6:0]  c1_addr = 0, h1_addr = 0, m1_addr;
  logic [31:0] c1_wdata = 0, h1_wdata = 0, c1_rdata, h1_rdata, m1_wdata, m1_rdata;
  logic        c1_done, c1_stall, h1_ack, m1_en, m1_we;
  logic        c3_req = 0, c3_we = 0, h3_req = 0, h3_we = 0;
  logic [6:0]  c3_addr = 0, h3_addr = 0, m3_addr;
  logic [31:0] c3_wdata = 0, h3_wdata = 0, c3_rdata, h3_rdata, m3_wdata, m3_rdata;
  logic        c3_done, c3_stall, h3_ack, m3_en, m3_we;
`ifdef DM_ARB_STATS_EN
  logic [31:0] s1_cpu, s1_host, s1_stall, s3_cpu, s3_host, s3_stall;
`endif

  dm_arbiter #(.AW(7), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_rdata(c1_rdata), .cpu_done(c1_done), .cpu_stall(c1_stall),
    .host_req(h1_req), .host_we(h1_we), .host_addr(h1_addr), .host_wdata(h1_wdata),
    .host_rdata(h1_rdata), .host_ack(h1_ack),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
`ifdef DM_ARB_STATS_EN
    , .stat_cpu_grants(s1_cpu), .stat_host_grants(s1_host), .stat_stall_cycles(s1_stall)
`endif
  );

  dm_arbiter #(.AW(7), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_rdata(c3_rdata), .cpu_done(c3_done), .cpu_stall(c3_stall),
    .host_req(h3_req), .host_we(h3_we), .host_addr(h3_addr), .host_wdata(h3_wdata),
    .host_rdata(h3_rdata), .host_ack(h3_ack),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_rdata(m3_rdata)
`ifdef DM_ARB_STATS_EN
    , .stat_cpu_grants(s3_cpu), .stat_host_grants(s3_host), .stat_stall_cycles(s3_stall)
`endif
  );

  // Memory models: read data appears MEM_LAT cycles after the mem_en cycle.
  logic [31:0] mem1 [128] = '{0: 32'h0000_1234, default: 32'h0};
  logic [31:0] mem3 [128] = '{0: 32'h0000_0005, default: 32'h0};
  logic [31:0] p1;
  logic [31:0] p3 [3];
  assign m1_rdata = p1;
  assign m3_rdata = p3[2];

  always @(posedge clk) begin
    if (m1_en) begin
      if (m1_we) mem1[m1_addr] <= m1_wdata;
      p1 <= mem1[m1_addr];
    end
    if (m3_en) begin
      if (m3_we) mem3[m3_addr] <= m3_wdata;
      p3[0] <= mem3[m3_addr];
    end
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    // Mid-cycle asynchronous reset
    #12 rst = 1'b1;
    #1;
    chk("rst_u1_done",  32'(c1_done), 0);
    chk("rst_u1_ack",   32'(h1_ack), 0);
    chk("rst_u1_en",    32'(m1_en), 0);
    chk("rst_u1_we",    32'(m1_we), 0);
    chk("rst_u1_addr",  32'(m1_addr), 0);
    chk("rst_u1_wdata", m1_wdata, 0);
    chk("rst_u1_crd",   c1_rdata, 0);
    chk("rst_u1_hrd",   h1_rdata, 0);
    chk("rst_u1_stall", 32'(c1_stall), 0);
    chk("rst_u3_outs",  32'({c3_done, h3_ack, m3_en, m3_we, c3_stall}), 0);
    chk("rst_u3_rd",    c3_rdata | h3_rdata | m3_wdata, 0);
    @(posedge clk);
    nxt();
    rst = 1'b0;

    // CPU write addr 2 = 5, then read it back
    c1_req = 1; c1_we = 1; c1_addr = 7'd2; c1_wdata = 32'd5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("wr_rd_stall", 32'(c1_stall), 32'(!(k == 3 || k == 7)));
      chk("wr_rd_en",    32'(m1_en), 32'(k == 1 || k == 5));
      chk("wr_rd_done",  32'(c1_done), 32'(k == 3 || k == 7));
      if (k == 1) begin
        chk("wr_we",    32'(m1_we), 1);
        chk("wr_addr",  32'(m1_addr), 2);
        chk("wr_wdata", m1_wdata, 5);
      end
      if (k == 5) chk("rd_we", 32'(m1_we), 0);
      if (k == 7) chk("rd_data", c1_rdata, 5);
      nxt();
      if (k == 3) c1_we = 0;
      if (k == 7) c1_req = 0;
    end

    // Simultaneous requests straight out of reset: CPU first
    do_reset();
    c1_req = 1; c1_we = 0; c1_addr = 7'd0;
    h1_req = 1; h1_we = 1; h1_addr = 7'd1; h1_wdata = 32'hA;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("sim_done",  32'(c1_done), 32'(k == 3));
      chk("sim_ack",   32'(h1_ack), 32'(k == 7));
      chk("sim_en",    32'(m1_en), 32'(k == 1 || k == 5));
      chk("sim_stall", 32'(c1_stall), 32'(k < 3));
      if (k == 3) chk("sim_crd", c1_rdata, 32'h1234);
      if (k == 5) chk("sim_host_mem", 32'({m1_we, m1_addr}), 32'({1'b1, 7'd1}));
      if (k == 5) chk("sim_host_wd", m1_wdata, 32'hA);
      if (k == 8) chk("sim_hrd_kept", h1_rdata, 0);
      nxt();
      if (k == 3) c1_req = 0;
      if (k == 7) h1_req = 0;
    end

    // Continuous contention: CPU, HOST, CPU, HOST
    do_reset();
    c1_req = 1; c1_we = 0; c1_addr = 7'd0;
    h1_req = 1; h1_we = 0; h1_addr = 7'd1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("rr_done", 32'(c1_done), 32'(k == 3 || k == 11));
      chk("rr_ack",  32'(h1_ack), 32'(k == 7 || k == 15));
      if (k == 7) chk("rr_hrd", h1_rdata, 32'hA);
      nxt();
      if (k == 15) begin c1_req = 0; h1_req = 0; end
    end
`ifdef DM_ARB_STATS_EN
    chk("st_cpu",   s1_cpu, 2);
    chk("st_host",  s1_host, 2);
    chk("st_stall", s1_stall, 14);
`endif

    // Request withdrawn right after grant still completes
    c1_req = 1; c1_we = 1; c1_addr = 7'd3; c1_wdata = 32'd7;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("wd_done", 32'(c1_done), 32'(k == 3));
      if (k == 1) chk("wd_en", 32'({m1_en, m1_we, m1_addr}), 32'({1'b1, 1'b1, 7'd3}));
      nxt();
      if (k == 0) c1_req = 0;
    end

    // Reset during WAIT (MEM_LAT=3): transaction abandoned
    c3_req = 1; c3_we = 0; c3_addr = 7'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rw_en", 32'(m3_en), 32'(k == 1));
      nxt();
    end
    rst = 1'b1; c3_req = 0;
    #1;
    chk("rw_rst_done", 32'(c3_done), 0);
    chk("rw_rst_rd",   c3_rdata, 0);
    nxt();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rw_no_done", 32'(c3_done), 0);
      chk("rw_rd0",     c3_rdata, 0);
      chk("rw_no_en",   32'(m3_en), 0);
      nxt();
    end

    // Host read with MEM_LAT=3; also confirms u3 is back in IDLE
    h3_req = 1; h3_we = 0; h3_addr = 7'd0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("l3_ack", 32'(h3_ack), 32'(k == 5));
      chk("l3_en",  32'(m3_en), 32'(k == 1));
      if (k == 5) chk("l3_hrd", h3_rdata, 5);
      nxt();
      if (k == 5) h3_req = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
